tpu_host_driver: RTL and testbench
==================================

TPU_HOST_DRIVER -- requirements
Module: tpu_host_driver

Interface
REQ-001 Parameter: READ_DELAY, default 0, number of idle cycles between the last load byte and the first readout byte (range 0-15).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a transaction; accepted only when ready=1.
REQ-005 ready  output  1  high in IDLE only.
REQ-006 a_mat  input  32  weight matrix {A11,A10,A01,A00}, int8 each, A00 in bits [7:0].
REQ-007 b_mat  input  32  input matrix {B11,B10,B01,B00}, int8 each, B00 in bits [7:0].
REQ-008 transpose_in  input  1  transpose request for the accepted transaction.
REQ-009 load_en  output  1  byte-strobe toward the array controller.
REQ-010 host_indata  output  8  byte stream toward array memory.
REQ-011 transpose  output  1  latched transpose_in, held for the whole transaction.
REQ-012 host_outdata  input  8  result byte stream from the array controller.
REQ-013 result  output  64  {C11,C10,C01,C00}, 16-bit signed each, C00 in bits [15:0].
REQ-014 result_valid  output  1  one-cycle pulse when result is updated.
REQ-015 busy  output  1  high in any state other than IDLE; always equals ~ready.

Function
REQ-016 States SHALL be IDLE, LOAD, WAIT, READ, DONE; a 3-bit byte counter idx SHALL index LOAD and READ.
REQ-017 IDLE: start=1 at a clock edge SHALL latch a_mat, b_mat, transpose_in, clear idx to 0, and enter LOAD next cycle.
REQ-018 start in any non-IDLE state SHALL be ignored; latched operands SHALL NOT change mid-transaction.
REQ-019 LOAD: load_en=1 for exactly 8 consecutive cycles; host_indata SHALL be A00,A01,A10,A11,B00,B01,B10,B11 for idx 0..7.
REQ-020 After idx=7 in LOAD: enter WAIT if READ_DELAY>0, else READ; idx SHALL wrap to 0.
REQ-021 WAIT: load_en=0, host_indata=0, for exactly READ_DELAY cycles, then READ.
REQ-022 READ: load_en=1, host_indata=0 for exactly 8 cycles; host_outdata SHALL be sampled every READ cycle.
REQ-023 READ byte mapping by idx: 0 C00[15:8], 1 C00[7:0], 2 C01[15:8], 3 C01[7:0], 4 C10[15:8], 5 C10[7:0], 6 C11[15:8], 7 C11[7:0].
REQ-024 Sampled bytes SHALL go to a shadow register; result SHALL update only on entry to DONE, so it stays stable during READ.
REQ-025 DONE: lasts one cycle; result_valid=1; load_en=0; next state IDLE.
REQ-026 start asserted in the DONE cycle SHALL be ignored; the earliest next acceptance is the following IDLE cycle.
REQ-027 Total latency from the start-accept edge to result_valid SHALL be 17+READ_DELAY cycles.
REQ-028 Bytes SHALL pass unmodified; no sign extension or arithmetic is performed.

Reset
REQ-029 rst=1 SHALL force IDLE, idx=0, load_en=0, host_indata=0, transpose=0, result=0, result_valid=0, busy=0, ready=1, and clear the shadow register.
REQ-030 rst asserted mid-transaction SHALL abort with no result_valid pulse; the next start is accepted the first cycle after rst deasserts.
REQ-031 rst SHALL take priority over start in the same cycle.

Verification
REQ-032 READ_DELAY=0; a_mat=32'h04030201, b_mat=32'h08070605, start pulse -> load_en high for 16 cycles; host_indata 01,02,03,04,05,06,07,08 then 8x00; result_valid pulses at cycle 17.
REQ-033 Readout bytes 00,13,00,16,00,2B,00,32 -> result=64'h0032_002B_0016_0013 on the result_valid cycle; result unchanged during READ.
REQ-034 READ_DELAY=3 -> load_en low for exactly 3 cycles between LOAD and READ; result_valid at cycle 20.
REQ-035 start held high continuously -> back-to-back transactions, one IDLE cycle between DONE and the next LOAD; transpose_in toggled mid-transaction does not change transpose.
REQ-036 rst pulsed at LOAD idx=4 -> load_en=0 and ready=1 the next cycle; no result_valid; a following start with new operands produces a correct stream.
REQ-037 Readout bytes FF,80,7F,FF,... -> C00=16'hFF80 and C01=16'h7FFF, placed bit-exact.

Source files
------------

// File: rtl/tpu_host_driver.sv
// Host-side driver for a 2x2 int8 systolic array: streams A/B operand bytes into
// the array, then collects eight result bytes and presents them as four int16 values.
module tpu_host_driver #(
  parameter int unsigned READ_DELAY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        ready,
  input  logic [31:0] a_mat,
  input  logic [31:0] b_mat,
  input  logic        transpose_in,
  output logic        load_en,
  output logic [7:0]  host_indata,
  output logic        transpose,
  input  logic [7:0]  host_outdata,
  output logic [63:0] result,
  output logic        result_valid,
  output logic        busy
);

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned OPS_W  = 64;
  localparam int unsigned RES_W  = 64;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WAIT = 3'd2,
    S_READ = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              r_state, w_state_nx;
  logic [IDX_W-1:0]    r_idx, w_idx_nx;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
  logic [OPS_W-1:0]    r_ops, w_ops_nx;
  logic [RES_W-1:0]    r_shadow, w_shadow_nx;
  logic [RES_W-1:0]    r_result, w_result_nx;
  logic                r_transpose, w_transpose_nx;
  logic                r_load_en, w_load_en_nx;
  logic [BYTE_W-1:0]   r_indata, w_indata_nx;
  logic                r_valid, w_valid_nx;
  logic                r_ready, w_ready_nx;
  logic                r_busy, w_busy_nx;
  logic [5:0]          w_rd_pos;
  logic [5:0]          w_ld_pos;

  // Readout byte idx lands in result byte idx^1 (high byte of each int16 arrives first)
  assign w_rd_pos = {r_idx ^ IDX_W'(1), 3'b000};
  assign w_ld_pos = {w_idx_nx, 3'b000};

  // Next-state, datapath and look-ahead output decode
  always_comb begin
    w_state_nx     = r_state;
    w_idx_nx       = r_idx;
    w_cnt_nx       = r_cnt;
    w_ops_nx       = r_ops;
    w_shadow_nx    = r_shadow;
    w_result_nx    = r_result;
    w_transpose_nx = r_transpose;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx     = S_LOAD;
          w_idx_nx       = '0;
          w_ops_nx       = {b_mat, a_mat};
          w_transpose_nx = transpose_in;
        end
      end
      S_LOAD: begin
        if (r_idx == IDX_W'(7)) begin
          w_idx_nx   = '0;
          w_cnt_nx   = '0;
          w_state_nx = (READ_DELAY > 0) ? S_WAIT : S_READ;
        end else begin
          w_idx_nx = r_idx + IDX_W'(1);
        end
      end
      S_WAIT: begin
        if (r_cnt == CNT_W'(READ_DELAY - 1)) begin
          w_state_nx = S_READ;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_READ: begin
        w_shadow_nx[w_rd_pos +: BYTE_W] = host_outdata;
        if (r_idx == IDX_W'(7)) begin
          w_idx_nx    = '0;
          w_state_nx  = S_DONE;
          w_result_nx = w_shadow_nx;
        end else begin
          w_idx_nx = r_idx + IDX_W'(1);
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    w_load_en_nx = (w_state_nx == S_LOAD) || (w_state_nx == S_READ);
    w_indata_nx  = (w_state_nx == S_LOAD) ? w_ops_nx[w_ld_pos +: BYTE_W] : '0;
    w_valid_nx   = (w_state_nx == S_DONE);
    w_ready_nx   = (w_state_nx == S_IDLE);
    w_busy_nx    = (w_state_nx != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_ops       <= '0;
      r_shadow    <= '0;
      r_result    <= '0;
      r_transpose <= 1'b0;
      r_load_en   <= 1'b0;
      r_indata    <= '0;
      r_valid     <= 1'b0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_idx       <= w_idx_nx;
      r_cnt       <= w_cnt_nx;
      r_ops       <= w_ops_nx;
      r_shadow    <= w_shadow_nx;
      r_result    <= w_result_nx;
      r_transpose <= w_transpose_nx;
      r_load_en   <= w_load_en_nx;
      r_indata    <= w_indata_nx;
      r_valid     <= w_valid_nx;
      r_ready     <= w_ready_nx;
      r_busy      <= w_busy_nx;
    end
  end

  assign ready        = r_ready;
  assign busy         = r_busy;
  assign load_en      = r_load_en;
  assign host_indata  = r_indata;
  assign transpose    = r_transpose;
  assign result       = r_result;
  assign result_valid = r_valid;

endmodule

// File: tb/tb_tpu_host_driver.sv
// Directed bench for tpu_host_driver: per-cycle vector tables for full transactions
// plus hand-written sequences for back-to-back, mid-transaction reset and read delay.
module tb_tpu_host_driver;

  typedef struct {
    logic [7:0] outdata;
    logic       exp_load_en;
    logic [7:0] exp_indata;
    logic       exp_valid;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start3 = 1'b0;
  logic [31:0] a_mat = '0;
  logic [31:0] b_mat = '0;
  logic        transpose_in = 1'b0;
  logic [7:0]  host_outdata = '0;

  logic        ready, load_en, transpose, result_valid, busy;
  logic [7:0]  host_indata;
  logic [63:0] result;
  logic        ready3, load_en3, transpose3, result_valid3, busy3;
  logic [7:0]  host_indata3;
  logic [63:0] result3;

  int checks = 0;
  int failures = 0;

  tpu_host_driver #(.READ_DELAY(0)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .a_mat(a_mat), .b_mat(b_mat), .transpose_in(transpose_in),
    .load_en(load_en), .host_indata(host_indata), .transpose(transpose),
    .host_outdata(host_outdata), .result(result),
    .result_valid(result_valid), .busy(busy)
  );

  tpu_host_driver #(.READ_DELAY(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .ready(ready3),
    .a_mat(a_mat), .b_mat(b_mat), .transpose_in(transpose_in),
    .load_en(load_en3), .host_indata(host_indata3), .transpose(transpose3),
    .host_outdata(host_outdata), .result(result3),
    .result_valid(result_valid3), .busy(busy3)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called in cycle 1 (first cycle after the accept edge); runs through the cycle after DONE.
  task automatic run_body(input logic [63:0] in_bytes, input logic [63:0] rd_bytes,
                          input logic [63:0] exp_res, input logic [63:0] prev_res,
                          input logic exp_tr);
    vec_t tbl [17];
    for (int n = 0; n < 17; n++) begin
      if (n < 8)       tbl[n] = '{8'h00, 1'b1, in_bytes[8*n +: 8], 1'b0};
      else if (n < 16) tbl[n] = '{rd_bytes[8*(n-8) +: 8], 1'b1, 8'h00, 1'b0};
      else             tbl[n] = '{8'h00, 1'b0, 8'h00, 1'b1};
    end
    for (int n = 0; n < 17; n++) begin
      host_outdata = tbl[n].outdata;
      chk($sformatf("load_en c%0d", n + 1), 64'(load_en), 64'(tbl[n].exp_load_en));
      chk($sformatf("host_indata c%0d", n + 1), 64'(host_indata), 64'(tbl[n].exp_indata));
      chk($sformatf("result_valid c%0d", n + 1), 64'(result_valid), 64'(tbl[n].exp_valid));
      chk($sformatf("busy c%0d", n + 1), 64'(busy), 64'(1'b1));
      chk($sformatf("transpose c%0d", n + 1), 64'(transpose), 64'(exp_tr));
      if (n < 16) chk($sformatf("result_stable c%0d", n + 1), result, prev_res);
      else        chk("result_done", result, exp_res);
      step();
    end
    chk("valid_after_done", 64'(result_valid), 64'(1'b0));
    chk("ready_after_done", 64'(ready), 64'(1'b1));
    chk("result_held", result, exp_res);
  endtask

  initial begin
    int guard;

    // Reset with start high: reset wins
    rst = 1'b1; start = 1'b1; a_mat = 32'h11111111;
    step(); step();
    rst = 1'b0; start = 1'b0;
    chk("rst_ready", 64'(ready), 64'(1'b1));
    chk("rst_busy", 64'(busy), 64'(1'b0));
    chk("rst_load_en", 64'(load_en), 64'(1'b0));
    chk("rst_indata", 64'(host_indata), 64'h0);
    chk("rst_result", result, 64'h0);
    chk("rst_valid", 64'(result_valid), 64'(1'b0));
    chk("rst_transpose", 64'(transpose), 64'(1'b0));
    step();

    // Basic transaction
    a_mat = 32'h04030201; b_mat = 32'h08070605; transpose_in = 1'b1; start = 1'b1;
    step();
    start = 1'b0; transpose_in = 1'b0;
    run_body(64'h0807060504030201, 64'h32002B0016001300,
             64'h0032_002B_0016_0013, 64'h0, 1'b1);

    // Bit-exact signed bytes
    a_mat = 32'h80FF7F01; b_mat = 32'hDEADBEEF; start = 1'b1;
    step();
    start = 1'b0;
    run_body(64'hDEADBEEF80FF7F01, 64'h00800100FF7F80FF,
             64'h8000_0001_7FFF_FF80, 64'h0032_002B_0016_0013, 1'b0);

    // Back-to-back with start held; operand/transpose changes mid-flight ignored
    a_mat = 32'h44332211; b_mat = 32'h88776655; transpose_in = 1'b1; start = 1'b1;
    step();
    chk("b2b_c1_indata", 64'(host_indata), 64'h11);
    a_mat = 32'hAABBCCDD; b_mat = 32'h01020304; transpose_in = 1'b0;
    step();
    chk("b2b_c2_indata", 64'(host_indata), 64'h22);
    chk("b2b_c2_transpose", 64'(transpose), 64'(1'b1));
    for (int n = 3; n <= 17; n++) step();
    chk("b2b_c17_valid", 64'(result_valid), 64'(1'b1));
    chk("b2b_c17_transpose", 64'(transpose), 64'(1'b1));
    step();
    chk("b2b_idle_ready", 64'(ready), 64'(1'b1));
    chk("b2b_idle_load_en", 64'(load_en), 64'(1'b0));
    step();
    chk("b2b_next_load_en", 64'(load_en), 64'(1'b1));
    chk("b2b_next_indata", 64'(host_indata), 64'hDD);
    chk("b2b_next_transpose", 64'(transpose), 64'(1'b0));
    start = 1'b0;
    guard = 0;
    while (!ready && guard < 40) begin step(); guard++; end
    chk("b2b_drain_timeout", 64'(guard < 40), 64'(1'b1));
    step();

    // Reset at LOAD idx=4, then a fresh transaction
    a_mat = 32'h0A0B0C0D; b_mat = 32'h0E0F1011; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    chk("mid_idx4_indata", 64'(host_indata), 64'h11);
    rst = 1'b1;
    step();
    chk("mid_rst_load_en", 64'(load_en), 64'(1'b0));
    chk("mid_rst_ready", 64'(ready), 64'(1'b1));
    chk("mid_rst_busy", 64'(busy), 64'(1'b0));
    chk("mid_rst_valid", 64'(result_valid), 64'(1'b0));
    chk("mid_rst_result", result, 64'h0);
    rst = 1'b0;
    a_mat = 32'h5A6B7C8D; b_mat = 32'h12345678; transpose_in = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    run_body(64'h123456785A6B7C8D, 64'h0102030405060708,
             64'h0201_0403_0605_0807, 64'h0, 1'b1);

    // READ_DELAY=3 instance: three idle cycles between LOAD and READ
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      chk($sformatf("rd3_load_en c%0d", n), 64'(load_en3),
          64'((n <= 8) || (n >= 12 && n <= 19)));
      chk($sformatf("rd3_valid c%0d", n), 64'(result_valid3), 64'(n == 20));
      step();
    end
    chk("rd3_ready_after", 64'(ready3), 64'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
